// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the 2-input gate self-test engine.
// Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Loadable 4-bit down-counter that paces the gate settle delay.
// The expire flag marks the last cycle of the settle window.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       expire
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expire = (count == 4'd1);

endmodule

// File: rtl/gate_response_checker.sv
// Self-test engine: walks a 2-input gate through all four vectors and scores y_obs.
// state  | meaning
// IDLE   | after reset, waiting for start
// APPLY  | drive vector v onto a_out/b_out, load settle timer
// SETTLE | wait for the gate output to settle
// SAMPLE | compare y_obs with the truth table, advance v
// DONE   | results valid, waiting for start
module gate_response_checker
  import gate_test_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_NAND,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_obs,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       first_fail_valid,
  output logic [1:0] first_fail_idx
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] vec_q;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_expire;
  logic [3:0] timer_count;
  logic       mismatch;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (SETTLE_LD),
    .count    (timer_count),
    .expire   (timer_expire)
  );

  // X/Z on the observed output must score as a failure, hence the case inequality.
  assign mismatch = (y_obs !== TRUTH_TABLE[vec_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = APPLY;
      end
      APPLY: begin
        timer_load = 1'b1;
        state_d    = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        timer_dec = 1'b1;
        if (timer_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        state_d = (vec_q == 2'd3) ? DONE : APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs follow the state one cycle later so nothing is combinational from start/y_obs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q            <= 2'd0;
      a_out            <= 1'b0;
      b_out            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= 3'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 2'd0;
    end else begin
      busy <= (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
      done <= (state_q == DONE) && !start;
      pass <= (state_q == DONE) && !start && (err_count == 3'd0);
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec_q            <= 2'd0;
            err_count        <= 3'd0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= 2'd0;
          end
        end
        APPLY: begin
          a_out <= vec_q[1];
          b_out <= vec_q[0];
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 3'd1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_q;
            end
          end
          if (vec_q != 2'd3) vec_q <= vec_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a modelled gate (4-bit function table) drives y_obs,
// and expected scores come from comparing that function against the truth table.
module tb_gate_response_checker;
  import gate_test_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // main instance: SETTLE_CYCLES=2
  logic [3:0] gate_fn = 4'd0;
  logic       start = 1'b0;
  logic       y_obs;
  logic       a_out, b_out, busy, done, pass, ffv;
  logic [2:0] err_count;
  logic [1:0] ffi;

  // second instance: SETTLE_CYCLES=0
  logic [3:0] gate_fn_z = 4'd0;
  logic       start_z = 1'b0;
  logic       y_obs_z;
  logic       a_z, b_z, busy_z, done_z, pass_z, ffv_z;
  logic [2:0] err_z;
  logic [1:0] ffi_z;

  assign y_obs   = gate_fn[{a_out, b_out}];
  assign y_obs_z = gate_fn_z[{a_z, b_z}];

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y_obs(y_obs),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_valid(ffv), .first_fail_idx(ffi)
  );

  gate_response_checker #(.TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .y_obs(y_obs_z),
    .a_out(a_z), .b_out(b_z), .busy(busy_z), .done(done_z), .pass(pass_z),
    .err_count(err_z), .first_fail_valid(ffv_z), .first_fail_idx(ffi_z)
  );

  // Reference model: number of input combinations where the gate disagrees with the table.
  function automatic int model_errs(input logic [3:0] fn, input logic [3:0] tt);
    int n = 0;
    for (int i = 0; i < 4; i++) if (fn[i] != tt[i]) n++;
    return n;
  endfunction

  // Lowest disagreeing input combination, or -1 if none.
  function automatic int model_first(input logic [3:0] fn, input logic [3:0] tt);
    for (int i = 0; i < 4; i++) if (fn[i] != tt[i]) return i;
    return -1;
  endfunction

  // Runs the main instance; optional extra start pulse at edge mid_edge (0 = none).
  task automatic run_main(input logic [3:0] fn, input int mid_edge,
                          output int done_edge, output int busy_cyc, output logic [7:0] ab_seq);
    gate_fn = fn;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    done_edge = -1; busy_cyc = 0; ab_seq = 8'd0;
    for (int k = 1; k <= 40 && done_edge < 0; k++) begin
      start = (k == mid_edge);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_edge = k;
      if ((k % 4) == 1 && k <= 13) ab_seq[2*((k-1)/4) +: 2] = {a_out, b_out};
    end
  endtask

  task automatic check_results(input string tag, input logic [3:0] fn, input int done_edge, input int busy_cyc);
    int e  = model_errs(fn, TT_NAND);
    int ff = model_first(fn, TT_NAND);
    tests_run++;
    if (done_edge !== 17) begin
      tests_failed++;
      $display("FAIL %s done_edge fn=%b got %0d want 17", tag, fn, done_edge);
    end
    tests_run++;
    if (busy_cyc !== 16) begin
      tests_failed++;
      $display("FAIL %s busy_cycles got %0d want 16", tag, busy_cyc);
    end
    tests_run++;
    if (err_count !== 3'(e)) begin
      tests_failed++;
      $display("FAIL %s err_count fn=%b got %0d want %0d", tag, fn, err_count, e);
    end
    tests_run++;
    if (pass !== (e == 0)) begin
      tests_failed++;
      $display("FAIL %s pass got %b want %b", tag, pass, (e == 0));
    end
    tests_run++;
    if (ffv !== (ff >= 0)) begin
      tests_failed++;
      $display("FAIL %s first_fail_valid got %b want %b", tag, ffv, (ff >= 0));
    end
    if (ff >= 0) begin
      tests_run++;
      if (ffi !== 2'(ff)) begin
        tests_failed++;
        $display("FAIL %s first_fail_idx got %0d want %0d", tag, ffi, ff);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({a_out, b_out, busy, done, pass, err_count, ffv, ffi} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_main outputs got %b want 0", {a_out, b_out, busy, done, pass, err_count, ffv, ffi});
    end
    tests_run++;
    if ({a_z, b_z, busy_z, done_z, pass_z, err_z, ffv_z, ffi_z} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_s0 outputs got %b want 0", {a_z, b_z, busy_z, done_z, pass_z, err_z, ffv_z, ffi_z});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nand();
    int de, bc; logic [7:0] ab;
    run_main(TT_NAND, 0, de, bc, ab);
    check_results("nand", TT_NAND, de, bc);
    tests_run++;
    if (ab !== 8'b11_10_01_00) begin
      tests_failed++;
      $display("FAIL nand ab_sequence got %b want 11100100", ab);
    end
  endtask

  task automatic test_stuck0();
    int de, bc; logic [7:0] ab;
    run_main(4'b0000, 0, de, bc, ab);
    check_results("stuck0", 4'b0000, de, bc);
  endtask

  task automatic test_all_wrong();
    int de, bc; logic [7:0] ab;
    run_main(~TT_NAND, 0, de, bc, ab);
    check_results("all_wrong", ~TT_NAND, de, bc);
  endtask

  task automatic test_random();
    int de, bc; logic [7:0] ab; logic [3:0] fn;
    for (int r = 0; r < 8; r++) begin
      fn = 4'($urandom_range(0, 15));
      run_main(fn, 0, de, bc, ab);
      check_results("random", fn, de, bc);
    end
  endtask

  task automatic test_back_to_back();
    int de, bc; logic [7:0] ab;
    run_main(TT_NAND, 9, de, bc, ab);
    check_results("mid_start", TT_NAND, de, bc);
    run_main(4'b0000, 0, de, bc, ab);
    check_results("pre_restart", 4'b0000, de, bc);
    gate_fn = TT_NAND;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    tests_run++;
    if ({done, pass, err_count, ffv} !== 6'd0) begin
      tests_failed++;
      $display("FAIL restart_clear got done=%b pass=%b err=%0d ffv=%b want all 0", done, pass, err_count, ffv);
    end
    de = -1;
    for (int k = 1; k <= 40 && de < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) de = k;
    end
    tests_run++;
    if (de !== 17 || pass !== 1'b1 || err_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL restart_run got done_edge=%0d pass=%b err=%0d want 17 1 0", de, pass, err_count);
    end
  endtask

  task automatic test_reset_midrun();
    int de, bc; logic [7:0] ab;
    gate_fn = 4'b0000;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (err_count !== 3'(model_errs(4'b0001 & 4'b0000, TT_NAND & 4'b0001)) || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_progress got err=%0d busy=%b want 1 1", err_count, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_out, b_out, busy, done, pass, err_count, ffv, ffi} !== 11'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset outputs got %b want 0", {a_out, b_out, busy, done, pass, err_count, ffv, ffi});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_main(TT_NAND, 0, de, bc, ab);
    check_results("after_reset", TT_NAND, de, bc);
  endtask

  task automatic test_settle0();
    int de, bc, e, ff; logic [7:0] ab; logic [3:0] fn;
    for (int r = 0; r < 4; r++) begin
      fn = (r == 0) ? TT_NAND : 4'($urandom_range(0, 15));
      gate_fn_z = fn;
      e  = model_errs(fn, TT_NAND);
      ff = model_first(fn, TT_NAND);
      @(negedge clk); start_z = 1'b1;
      @(posedge clk);
      @(negedge clk); start_z = 1'b0;
      de = -1; bc = 0; ab = 8'd0;
      for (int k = 1; k <= 30 && de < 0; k++) begin
        @(negedge clk);
        if (busy_z === 1'b1) bc++;
        if (done_z === 1'b1) de = k;
        if ((k % 2) == 1 && k <= 7) ab[2*((k-1)/2) +: 2] = {a_z, b_z};
      end
      tests_run++;
      if (de !== 9 || bc !== 8) begin
        tests_failed++;
        $display("FAIL s0_timing got done_edge=%0d busy=%0d want 9 8", de, bc);
      end
      tests_run++;
      if (ab !== 8'b11_10_01_00) begin
        tests_failed++;
        $display("FAIL s0_ab_sequence got %b want 11100100", ab);
      end
      tests_run++;
      if (err_z !== 3'(e) || pass_z !== (e == 0) || ffv_z !== (ff >= 0)) begin
        tests_failed++;
        $display("FAIL s0_score fn=%b got err=%0d pass=%b ffv=%b want %0d %b %b", fn, err_z, pass_z, ffv_z, e, (e == 0), (ff >= 0));
      end
      if (ff >= 0) begin
        tests_run++;
        if (ffi_z !== 2'(ff)) begin
          tests_failed++;
          $display("FAIL s0_first_idx got %0d want %0d", ffi_z, ff);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_stuck0();
    test_all_wrong();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_settle0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
